// File: rtl/jtframe_vidgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtframe_vidgen                                                |
// | Purpose  : Raster video timing generator. Divides clk down to a pixel    |
// |            enable and produces pixel/line counters together with          |
// |            blanking, sync and frame-parity signals.                      |
// | Ports    : clk      in   system clock                                    |
// |            rst      in   synchronous active-high reset                   |
// |            pxl_cen  out  pixel clock enable, one clk wide                |
// |            H        out  [8:0] horizontal pixel count                    |
// |            V        out  [8:0] vertical line count                       |
// |            HB, VB   out  blanking, polarity set by BLKPOL                |
// |            HS, VS   out  sync, always active-high                        |
// |            frame    out  toggles once per frame                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module jtframe_vidgen #(
   parameter int CEN_DIV  = 4,
   parameter int HTOTAL   = 384,
   parameter int HB_START = 256,
   parameter int HB_END   = 0,
   parameter int HS_START = 304,
   parameter int HS_END   = 336,
   parameter int VTOTAL   = 264,
   parameter int VB_START = 224,
   parameter int VB_END   = 0,
   parameter int VS_START = 236,
   parameter int VS_END   = 240,
   parameter int BLKPOL   = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pxl_cen,
   output logic [8:0] H,
   output logic [8:0] V,
   output logic       HB,
   output logic       VB,
   output logic       HS,
   output logic       VS,
   output logic       frame
);

   localparam int              CNT_W    = (CEN_DIV > 1) ? $clog2(CEN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CEN_DIV - 1);
   localparam logic [8:0]      H_LAST   = 9'(HTOTAL - 1);
   localparam logic [8:0]      V_LAST   = 9'(VTOTAL - 1);
   localparam logic [8:0]      HBS      = 9'(HB_START);
   localparam logic [8:0]      HBE      = 9'(HB_END);
   localparam logic [8:0]      HSS      = 9'(HS_START);
   localparam logic [8:0]      HSE      = 9'(HS_END);
   localparam logic [8:0]      VBS      = 9'(VB_START);
   localparam logic [8:0]      VBE      = 9'(VB_END);
   localparam logic [8:0]      VSS      = 9'(VS_START);
   localparam logic [8:0]      VSE      = 9'(VS_END);

   // Blank window wraps through zero: active from START to the end of the
   // count and again below END. END=0 leaves only the upper part.
   function automatic logic blank_dec(input logic [8:0] cnt,
                                      input logic [8:0] w_start,
                                      input logic [8:0] w_end);
      return (cnt >= w_start) || (cnt < w_end);
   endfunction

   // Sync window never wraps; END<=START yields an empty window.
   function automatic logic sync_dec(input logic [8:0] cnt,
                                     input logic [8:0] w_start,
                                     input logic [8:0] w_end);
      return (cnt >= w_start) && (cnt < w_end);
   endfunction

   function automatic logic blk_out(input logic act);
      return (BLKPOL != 0) ? act : ~act;
   endfunction

   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             pxl_cen_q, pxl_cen_d;
   logic [8:0]       h_q,       h_d;
   logic [8:0]       v_q,       v_d;
   logic             hb_q,      hb_d;
   logic             vb_q,      vb_d;
   logic             hs_q,      hs_d;
   logic             vs_q,      vs_d;
   logic             frame_q,   frame_d;

   logic             tick;
   logic             h_wrap;
   logic             v_wrap;

   // The pixel enable and the counter advance are both taken from the
   // divider terminal count, so H/V and the decodes change on the very
   // edge where pxl_cen goes high.
   always_comb begin
      tick      = (cnt_q == CNT_LAST);
      h_wrap    = (h_q == H_LAST);
      v_wrap    = (v_q == V_LAST);

      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      pxl_cen_d = tick;
      h_d       = h_q;
      v_d       = v_q;
      frame_d   = frame_q;

      if (tick) begin
         h_d = h_wrap ? 9'd0 : h_q + 9'd1;
         if (h_wrap) begin
            v_d = v_wrap ? 9'd0 : v_q + 9'd1;
            if (v_wrap) begin
               frame_d = ~frame_q;
            end
         end
      end

      // Decodes look at the next counter values so they carry no lag.
      hb_d = blk_out(blank_dec(h_d, HBS, HBE));
      vb_d = blk_out(blank_dec(v_d, VBS, VBE));
      hs_d = sync_dec(h_d, HSS, HSE);
      vs_d = sync_dec(v_d, VSS, VSE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         pxl_cen_q <= 1'b0;
         h_q       <= 9'd0;
         v_q       <= 9'd0;
         hb_q      <= blk_out(blank_dec(9'd0, HBS, HBE));
         vb_q      <= blk_out(blank_dec(9'd0, VBS, VBE));
         hs_q      <= 1'b0;
         vs_q      <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pxl_cen_q <= pxl_cen_d;
         h_q       <= h_d;
         v_q       <= v_d;
         hb_q      <= hb_d;
         vb_q      <= vb_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         frame_q   <= frame_d;
      end
   end

   assign pxl_cen = pxl_cen_q;
   assign H       = h_q;
   assign V       = v_q;
   assign HB      = hb_q;
   assign VB      = vb_q;
   assign HS      = hs_q;
   assign VS      = vs_q;
   assign frame   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_vidgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtframe_vidgen                                             |
// | Purpose  : Directed self-checking bench for jtframe_vidgen. Five        |
// |            instances share clk/rst: default, BLKPOL=0, CEN_DIV=1,        |
// |            CEN_DIV=3 (empty HS window) and a small-raster CEN_DIV=2.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_jtframe_vidgen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic       pxl_def, hb_def, vb_def, hs_def, vs_def, fr_def;
   logic [8:0] h_def, v_def;
   logic       pxl_pol, hb_pol, vb_pol, hs_pol, vs_pol, fr_pol;
   logic [8:0] h_pol, v_pol;
   logic       pxl_c1, hb_c1, vb_c1, hs_c1, vs_c1, fr_c1;
   logic [8:0] h_c1, v_c1;
   logic       pxl_c3, hb_c3, vb_c3, hs_c3, vs_c3, fr_c3;
   logic [8:0] h_c3, v_c3;
   logic       pxl_sc, hb_sc, vb_sc, hs_sc, vs_sc, fr_sc;
   logic [8:0] h_sc, v_sc;

   jtframe_vidgen u_def (
      .clk(clk), .rst(rst), .pxl_cen(pxl_def), .H(h_def), .V(v_def),
      .HB(hb_def), .VB(vb_def), .HS(hs_def), .VS(vs_def), .frame(fr_def));

   jtframe_vidgen #(.BLKPOL(0)) u_pol (
      .clk(clk), .rst(rst), .pxl_cen(pxl_pol), .H(h_pol), .V(v_pol),
      .HB(hb_pol), .VB(vb_pol), .HS(hs_pol), .VS(vs_pol), .frame(fr_pol));

   jtframe_vidgen #(.CEN_DIV(1)) u_c1 (
      .clk(clk), .rst(rst), .pxl_cen(pxl_c1), .H(h_c1), .V(v_c1),
      .HB(hb_c1), .VB(vb_c1), .HS(hs_c1), .VS(vs_c1), .frame(fr_c1));

   jtframe_vidgen #(.CEN_DIV(3), .HS_START(100), .HS_END(50)) u_c3 (
      .clk(clk), .rst(rst), .pxl_cen(pxl_c3), .H(h_c3), .V(v_c3),
      .HB(hb_c3), .VB(vb_c3), .HS(hs_c3), .VS(vs_c3), .frame(fr_c3));

   jtframe_vidgen #(.CEN_DIV(2), .HTOTAL(24), .HB_START(16), .HB_END(2),
                    .HS_START(18), .HS_END(21), .VTOTAL(12), .VB_START(9),
                    .VB_END(1), .VS_START(10), .VS_END(11)) u_sc (
      .clk(clk), .rst(rst), .pxl_cen(pxl_sc), .H(h_sc), .V(v_sc),
      .HB(hb_sc), .VB(vb_sc), .HS(hs_sc), .VS(vs_sc), .frame(fr_sc));

   int n_vec = 0;
   int n_err = 0;

   // c_now counts rising edges since the most recent reset release.
   int   c_now;
   bit   trk;
   int   pc_def, pc_c3, pc_sc, gap_def, gap_bad, c1_low, pol_bad, c3_hs;
   int   fr_tog, bad_upd;
   logic [21:0] prev_def, prev_sc;
   logic        prev_fr_sc;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c_now++;
         if (trk) begin
            pc_def += int'(pxl_def);
            pc_c3  += int'(pxl_c3);
            pc_sc  += int'(pxl_sc);
            gap_def++;
            if (pxl_def) begin
               if (gap_def != 4) gap_bad++;
               gap_def = 0;
            end
            if (!pxl_def && ({h_def, v_def, hb_def, vb_def, hs_def, vs_def} !== prev_def))
               bad_upd++;
            if (!pxl_sc && ({h_sc, v_sc, hb_sc, vb_sc, hs_sc, vs_sc} !== prev_sc))
               bad_upd++;
            if (pxl_c1 !== 1'b1) c1_low++;
            if (hb_pol !== ~hb_def || vb_pol !== ~vb_def || hs_pol !== hs_def ||
                vs_pol !== vs_def || h_pol !== h_def || v_pol !== v_def)
               pol_bad++;
            if (hs_c3 !== 1'b0) c3_hs++;
            if (fr_sc !== prev_fr_sc) fr_tog++;
         end
         prev_def   = {h_def, v_def, hb_def, vb_def, hs_def, vs_def};
         prev_sc    = {h_sc, v_sc, hb_sc, vb_sc, hs_sc, vs_sc};
         prev_fr_sc = fr_sc;
      end
   endtask

   task automatic adv_to(input int target);
      adv(target - c_now);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      c_now = 0; trk = 0;
      pc_def = 0; pc_c3 = 0; pc_sc = 0; gap_def = 0; gap_bad = 0;
      c1_low = 0; pol_bad = 0; c3_hs = 0; fr_tog = 0; bad_upd = 0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_def_h",   32'(h_def),   0);
      chk("rst_def_v",   32'(v_def),   0);
      chk("rst_def_pxl", 32'(pxl_def), 0);
      chk("rst_def_hbvb", 32'({hb_def, vb_def, hs_def, vs_def, fr_def}), 0);
      chk("rst_pol_hbvb", 32'({hb_pol, vb_pol}), 3);
      chk("rst_sc_hbvb",  32'({hb_sc, vb_sc, hs_sc, vs_sc}), 12);
      chk("rst_c1_pxl",  32'(pxl_c1),  0);

      // Release
      rst = 1'b0;
      c_now = 0;
      trk = 1;
      prev_def   = {h_def, v_def, hb_def, vb_def, hs_def, vs_def};
      prev_sc    = {h_sc, v_sc, hb_sc, vb_sc, hs_sc, vs_sc};
      prev_fr_sc = fr_sc;

      adv_to(1);
      chk("c1_def_pxl", 32'(pxl_def), 0);
      chk("c1_c1_pxl",  32'(pxl_c1),  1);
      chk("c1_c1_h",    32'(h_c1),    1);
      adv_to(2);
      chk("c2_c1_h",    32'(h_c1),    2);
      adv_to(3);
      chk("c3_c3_pxl",  32'(pxl_c3),  1);
      chk("c3_c3_h",    32'(h_c3),    1);
      chk("c3_def_pxl", 32'(pxl_def), 0);
      adv_to(4);
      chk("c4_def_pxl", 32'(pxl_def), 1);
      chk("c4_def_h",   32'(h_def),   1);
      chk("c4_c3_pxl",  32'(pxl_c3),  0);
      chk("c4_c1_h",    32'(h_c1),    4);
      adv_to(5);
      chk("c5_def_pxl", 32'(pxl_def), 0);
      chk("c5_def_h",   32'(h_def),   1);

      // Small raster: vertical windows and frame wrap
      adv_to(431); chk("sc_vb_pre",  32'({v_sc, vb_sc}), {9'd8, 1'b0});
      adv_to(432); chk("sc_vb_rise", 32'({h_sc, v_sc, vb_sc}), {9'd0, 9'd9, 1'b1});
      adv_to(479); chk("sc_vs_pre",  32'({v_sc, vs_sc}), {9'd9, 1'b0});
      adv_to(480); chk("sc_vs_rise", 32'({v_sc, vs_sc}), {9'd10, 1'b1});
      adv_to(527); chk("sc_vs_last", 32'({h_sc, v_sc, vs_sc}), {9'd23, 9'd10, 1'b1});
      adv_to(528); chk("sc_vs_fall", 32'({v_sc, vs_sc}), {9'd11, 1'b0});
      adv_to(575); chk("sc_wrap_pre", 32'({h_sc, v_sc, vb_sc, hb_sc, fr_sc, pxl_sc}),
                       {9'd23, 9'd11, 1'b1, 1'b1, 1'b0, 1'b0});
      adv_to(576); chk("sc_wrap", 32'({h_sc, v_sc, vb_sc, hb_sc, fr_sc, pxl_sc}),
                       {9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1});
      adv_to(624); chk("sc_vb_fall", 32'({h_sc, v_sc, vb_sc, hb_sc}),
                       {9'd0, 9'd1, 1'b0, 1'b1});
      adv_to(626); chk("sc_hb_h1",   32'({h_sc, hb_sc}), {9'd1, 1'b1});
      adv_to(628); chk("sc_hb_fall", 32'({h_sc, hb_sc}), {9'd2, 1'b0});
      adv_to(654); chk("sc_hb_pre",  32'({h_sc, hb_sc}), {9'd15, 1'b0});
      adv_to(656); chk("sc_hb_rise", 32'({h_sc, hb_sc}), {9'd16, 1'b1});
      adv_to(658); chk("sc_hs_pre",  32'({h_sc, hs_sc}), {9'd17, 1'b0});
      adv_to(660); chk("sc_hs_rise", 32'({h_sc, hs_sc}), {9'd18, 1'b1});
      adv_to(664); chk("sc_hs_last", 32'({h_sc, hs_sc}), {9'd20, 1'b1});
      adv_to(666); chk("sc_hs_fall", 32'({h_sc, hs_sc}), {9'd21, 1'b0});

      // Default raster: horizontal windows and line wrap
      adv_to(1023); chk("def_hb_pre",  32'({h_def, hb_def, pxl_def}), {9'd255, 1'b0, 1'b0});
      adv_to(1024); chk("def_hb_rise", 32'({h_def, hb_def, hs_def, pxl_def}),
                        {9'd256, 1'b1, 1'b0, 1'b1});
                    chk("pol_hb_rise", 32'(hb_pol), 0);
      adv_to(1215); chk("def_hs_pre",  32'({h_def, hs_def}), {9'd303, 1'b0});
      adv_to(1216); chk("def_hs_rise", 32'({h_def, hs_def}), {9'd304, 1'b1});
      adv_to(1343); chk("def_hs_last", 32'({h_def, hs_def}), {9'd335, 1'b1});
      adv_to(1344); chk("def_hs_fall", 32'({h_def, hs_def}), {9'd336, 1'b0});
      adv_to(1535); chk("def_line_end", 32'({h_def, v_def, hb_def}), {9'd383, 9'd0, 1'b1});
      adv_to(1536); chk("def_line_wrap", 32'({h_def, v_def, hb_def, vb_def, pxl_def, fr_def}),
                        {9'd0, 9'd1, 1'b0, 1'b0, 1'b1, 1'b0});
                    chk("pol_vb",   32'(vb_pol), 1);
                    chk("c1_hv",    32'({h_c1, v_c1}), {9'd0, 9'd4});
                    chk("c3_hv",    32'({h_c3, v_c3}), {9'd128, 9'd1});
                    chk("sc_hv",    32'({h_sc, v_sc}), {9'd0, 9'd8});

      // Aggregates over the first 1536 cycles
      chk("def_pxl_count", pc_def, 384);
      chk("def_pxl_gap",   gap_bad, 0);
      chk("c3_pxl_count",  pc_c3, 512);
      chk("sc_pxl_count",  pc_sc, 768);
      chk("sc_frame_tog",  fr_tog, 2);
      chk("upd_off_cen",   bad_upd, 0);
      chk("c1_cen_low",    c1_low, 0);
      chk("pol_mirror",    pol_bad, 0);
      chk("c3_hs_empty",   c3_hs, 0);

      // Mid-line reset one cycle before a pixel enable would fire
      trk = 0;
      adv_to(1939);
      chk("pre_rst_def", 32'({h_def, v_def, pxl_def}), {9'd100, 9'd1, 1'b0});
      chk("pre_rst_sc_fr", 32'(fr_sc), 1);
      rst = 1'b1;
      adv(1);
      rst = 1'b0;
      c_now = 0;
      chk("mid_rst_def", 32'({h_def, v_def, pxl_def, fr_def, hs_def}),
                         {9'd0, 9'd0, 1'b0, 1'b0, 1'b0});
      chk("mid_rst_c1_pxl", 32'(pxl_c1), 0);
      chk("mid_rst_sc", 32'({h_sc, v_sc, hb_sc, vb_sc, fr_sc}),
                        {9'd0, 9'd0, 1'b1, 1'b1, 1'b0});
      for (int k = 1; k <= 3; k++) begin
         adv(1);
         chk("rel_def_idle", 32'({h_def, pxl_def}), {9'd0, 1'b0});
      end
      adv(1);
      chk("rel_def_first", 32'({h_def, pxl_def}), {9'd1, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
